// File: rtl/call_dispatcher.sv
// Floor-call dispatcher: debounces four call buttons, latches pending calls and
// offers one target at a time to the elevator controller. Optional macro: CALL_DISPATCH_SCAN_EN.
module call_dispatcher #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_in,
  input  logic [1:0] current_floor,
  input  logic       served,
  input  logic       req_ack,
  output logic       req_valid,
  output logic [1:0] req_floor,
  output logic [3:0] pending,
  output logic       dir_up
);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_SERVE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] sync1, sync2, level, rise, clear, avail;
  logic [7:0] cnt [4];
  logic [1:0] target;
  logic       at_target, withdraw, offer_ack;

  // NOTE: every register below uses non-blocking assignments so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= call_in;
      sync2 <= sync1;
    end
  end

  // A level flips only on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int n = 0; n < 4; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (sync2[n] == level[n]) begin
          cnt[n] <= '0;
        end else if (cnt[n] == CNT_LAST) begin
          level[n] <= sync2[n];
          cnt[n]   <= '0;
        end else begin
          cnt[n] <= cnt[n] + 8'd1;
        end
      end
    end
  end

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    rise = '0;
    for (int n = 0; n < 4; n++)
      rise[n] = sync2[n] && !level[n] && (cnt[n] == CNT_LAST);
  end

  assign clear     = served ? (4'b0001 << current_floor) : 4'b0000;
  assign avail     = pending & ~clear;
  assign at_target = (current_floor == req_floor);
  assign withdraw  = (state == OFFER) && served && at_target;
  assign offer_ack = (state == OFFER) && req_ack && !withdraw;

  // Clear beats a same-cycle press for the served floor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending | rise) & ~clear;
  end

`ifdef CALL_DISPATCH_SCAN_EN
  logic       above_hit, below_hit;
  logic [1:0] above, below;

  // Nearest strictly beyond the car in the travel direction, else nearest behind.
  always_comb begin
    above_hit = 1'b0;
    above     = '0;
    below_hit = 1'b0;
    below     = '0;
    for (int i = 3; i >= 0; i--)
      if (avail[i] && (i > int'(current_floor))) begin
        above_hit = 1'b1;
        above     = 2'(i);
      end
    for (int i = 0; i < 4; i++)
      if (avail[i] && (i < int'(current_floor))) begin
        below_hit = 1'b1;
        below     = 2'(i);
      end
    if (dir_up) target = above_hit ? above : (below_hit ? below : current_floor);
    else        target = below_hit ? below : (above_hit ? above : current_floor);
  end
`else
  always_comb begin
    target = '0;
    for (int i = 3; i >= 0; i--)
      if (avail[i]) target = 2'(i);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (|avail) state_next = OFFER;
      OFFER:      if (withdraw) state_next = IDLE;
                  else if (req_ack) state_next = WAIT_SERVE;
      WAIT_SERVE: if (served && at_target) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_floor <= '0;
      dir_up    <= 1'b1;
    end else begin
      if ((state == IDLE) && (|avail)) req_floor <= target;
      if (offer_ack) begin
        if (req_floor > current_floor)      dir_up <= 1'b1;
        else if (req_floor < current_floor) dir_up <= 1'b0;
      end
    end
  end

  assign req_valid = (state == OFFER);

endmodule
